// File: rtl/bp_fe_bht_ctrl_if.sv
// Requester-side bundle of the BHT sequencing controller.
// master: front-end requester (drives lookup/update requests, receives responses)
// slave : bp_fe_bht_ctrl (accepts requests, returns lookup responses)
//   lookup_v_i/lookup_idx_i/lookup_ready_o        lookup request handshake
//   lookup_v_o/lookup_cnt_o/lookup_pred_o         lookup response
//   upd_v_i/upd_idx_i/upd_cnt_i/upd_taken_i/upd_ready_o  resolution update handshake
interface bp_fe_bht_ctrl_if #(
  parameter int unsigned bht_idx_width_p   = 9,
  parameter int unsigned bp_cnt_sat_bits_p = 2
);
  logic                         lookup_v_i;
  logic [bht_idx_width_p-1:0]   lookup_idx_i;
  logic                         lookup_ready_o;
  logic                         lookup_v_o;
  logic [bp_cnt_sat_bits_p-1:0] lookup_cnt_o;
  logic                         lookup_pred_o;
  logic                         upd_v_i;
  logic [bht_idx_width_p-1:0]   upd_idx_i;
  logic [bp_cnt_sat_bits_p-1:0] upd_cnt_i;
  logic                         upd_taken_i;
  logic                         upd_ready_o;

  modport master (
    output lookup_v_i, lookup_idx_i, upd_v_i, upd_idx_i, upd_cnt_i, upd_taken_i,
    input  lookup_ready_o, lookup_v_o, lookup_cnt_o, lookup_pred_o, upd_ready_o
  );

  modport slave (
    input  lookup_v_i, lookup_idx_i, upd_v_i, upd_idx_i, upd_cnt_i, upd_taken_i,
    output lookup_ready_o, lookup_v_o, lookup_cnt_o, lookup_pred_o, upd_ready_o
  );
endinterface

// File: rtl/bp_fe_bht_ctrl.sv
// Sequencing controller for the front-end bimodal BHT.
// After reset it sweeps every entry to weak-not-taken, then shares the
// single-ported table between prediction lookups and buffered resolution
// updates. Saturating-counter arithmetic is done here at update enqueue.
// Ports:
//   clk_i, reset_i (synchronous, active-low)
//   init_done_o          table sweep complete
//   fe                   requester interface (slave side)
//   bht_v_o/bht_w_o/bht_idx_o/bht_data_o  table access, combinational
//   bht_data_i           table read data, one cycle after a read
module bp_fe_bht_ctrl #(
  parameter int unsigned bht_idx_width_p   = 9,
  parameter int unsigned bp_cnt_sat_bits_p = 2,
  parameter int unsigned upd_fifo_els_p    = 4
) (
  input  logic                         clk_i,
  input  logic                         reset_i,
  output logic                         init_done_o,
  bp_fe_bht_ctrl_if.slave              fe,
  output logic                         bht_v_o,
  output logic                         bht_w_o,
  output logic [bht_idx_width_p-1:0]   bht_idx_o,
  output logic [bp_cnt_sat_bits_p-1:0] bht_data_o,
  input  logic [bp_cnt_sat_bits_p-1:0] bht_data_i
);

  localparam int unsigned idx_w = bht_idx_width_p;
  localparam int unsigned sat_w = bp_cnt_sat_bits_p;
  localparam int unsigned ptr_w = $clog2(upd_fifo_els_p);
  localparam int unsigned occ_w = ptr_w + 1;

  localparam logic [sat_w-1:0] cnt_max = '1;
  localparam logic [sat_w-1:0] cnt_weak_nt = {1'b0, {(sat_w-1){1'b1}}};

  typedef enum logic {e_init, e_run} state_e;

  typedef struct packed {
    logic [idx_w-1:0] idx;
    logic [sat_w-1:0] cnt;
  } upd_entry_t;

  state_e            state_q, state_n;
  logic [idx_w-1:0]  sweep_q, sweep_n;
  logic [ptr_w-1:0]  rd_q, rd_n, wr_q, wr_n;
  logic [occ_w-1:0]  occ_q, occ_n;
  logic              lookup_v_q;
  upd_entry_t        fifo_q [upd_fifo_els_p];

  upd_entry_t        head;
  upd_entry_t        enq_entry;
  logic              fifo_full, fifo_empty;
  logic              lookup_fire, deq, enq, cnt_changes;
  logic [sat_w-1:0]  new_cnt;

  assign fifo_full  = (occ_q == occ_w'(upd_fifo_els_p));
  assign fifo_empty = (occ_q == '0);
  assign head       = fifo_q[rd_q];

  // Control state, sweep index, FIFO pointers and lookup response valid
  always_ff @(posedge clk_i) begin
    if (!reset_i) begin
      state_q    <= e_init;
      sweep_q    <= '0;
      rd_q       <= '0;
      wr_q       <= '0;
      occ_q      <= '0;
      lookup_v_q <= 1'b0;
    end else begin
      state_q    <= state_n;
      sweep_q    <= sweep_n;
      rd_q       <= rd_n;
      wr_q       <= wr_n;
      occ_q      <= occ_n;
      lookup_v_q <= lookup_fire;
    end
  end

  // FIFO storage; contents are meaningless while occupancy says empty
  always_ff @(posedge clk_i) begin
    if (enq) begin
      fifo_q[wr_q] <= enq_entry;
    end
  end

  // Next state, arbitration and table access; everything is held at zero while reset is low
  always_comb begin
    state_n           = state_q;
    sweep_n           = sweep_q;
    init_done_o       = 1'b0;
    fe.lookup_ready_o = 1'b0;
    fe.upd_ready_o    = 1'b0;
    bht_v_o           = 1'b0;
    bht_w_o           = 1'b0;
    bht_idx_o         = '0;
    bht_data_o        = '0;
    lookup_fire       = 1'b0;
    deq               = 1'b0;
    enq               = 1'b0;
    cnt_changes       = 1'b0;
    new_cnt           = fe.upd_cnt_i;
    enq_entry         = '{idx: fe.upd_idx_i, cnt: new_cnt};

    if (reset_i) begin
      if (state_q == e_init) begin
        bht_v_o    = 1'b1;
        bht_w_o    = 1'b1;
        bht_idx_o  = sweep_q;
        bht_data_o = cnt_weak_nt;
        sweep_n    = sweep_q + idx_w'(1);
        if (sweep_q == '1) begin
          state_n = e_run;
        end
      end else begin
        init_done_o       = 1'b1;
        fe.lookup_ready_o = !fifo_full;
        fe.upd_ready_o    = !fifo_full;

        // A full FIFO must drain, otherwise lookups take priority over drains
        if (fifo_full) begin
          deq = 1'b1;
        end else if (fe.lookup_v_i) begin
          lookup_fire = 1'b1;
          bht_v_o     = 1'b1;
          bht_idx_o   = fe.lookup_idx_i;
        end else if (!fifo_empty) begin
          deq = 1'b1;
        end

        if (deq) begin
          bht_v_o    = 1'b1;
          bht_w_o    = 1'b1;
          bht_idx_o  = head.idx;
          bht_data_o = head.cnt;
        end

        // Saturated updates are accepted but need no table write
        if (fe.upd_taken_i && (fe.upd_cnt_i != cnt_max)) begin
          new_cnt     = fe.upd_cnt_i + sat_w'(1);
          cnt_changes = 1'b1;
        end else if (!fe.upd_taken_i && (fe.upd_cnt_i != '0)) begin
          new_cnt     = fe.upd_cnt_i - sat_w'(1);
          cnt_changes = 1'b1;
        end
        enq_entry = '{idx: fe.upd_idx_i, cnt: new_cnt};
        enq       = fe.upd_v_i && !fifo_full && cnt_changes;
      end
    end

    rd_n  = rd_q + ptr_w'(deq);
    wr_n  = wr_q + ptr_w'(enq);
    occ_n = occ_q + occ_w'(enq) - occ_w'(deq);
  end

  assign fe.lookup_v_o    = lookup_v_q && reset_i;
  assign fe.lookup_cnt_o  = bht_data_i;
  assign fe.lookup_pred_o = bht_data_i[sat_w-1];

endmodule

// File: tb/tb_bp_fe_bht_ctrl.sv
// Bench for bp_fe_bht_ctrl: a behavioural table/FIFO model predicts every
// table write and lookup response; a separate monitor pops and compares them.
module tb_bp_fe_bht_ctrl;

  localparam int unsigned IW  = 9;
  localparam int unsigned CW  = 2;
  localparam int unsigned FE  = 4;
  localparam int          N   = 1 << IW;
  localparam int          MAX = (1 << CW) - 1;
  localparam int          WNT = (1 << (CW - 1)) - 1;

  logic          clk = 1'b0;
  logic          reset_i;
  logic          init_done_o;
  logic          bht_v_o, bht_w_o;
  logic [IW-1:0] bht_idx_o;
  logic [CW-1:0] bht_data_o;
  logic [CW-1:0] bht_data_i;

  always #5 clk = ~clk;

  bp_fe_bht_ctrl_if #(.bht_idx_width_p(IW), .bp_cnt_sat_bits_p(CW)) fe_if ();

  bp_fe_bht_ctrl #(
    .bht_idx_width_p(IW), .bp_cnt_sat_bits_p(CW), .upd_fifo_els_p(FE)
  ) dut (
    .clk_i(clk), .reset_i(reset_i), .init_done_o(init_done_o), .fe(fe_if),
    .bht_v_o(bht_v_o), .bht_w_o(bht_w_o), .bht_idx_o(bht_idx_o),
    .bht_data_o(bht_data_o), .bht_data_i(bht_data_i)
  );

  // Single-port storage macro behind the controller
  logic [CW-1:0] mem [N];
  always @(posedge clk) begin
    if (bht_v_o && bht_w_o) mem[bht_idx_o] <= bht_data_o;
    if (bht_v_o && !bht_w_o) bht_data_i <= mem[bht_idx_o];
  end

  typedef struct {
    int idx;
    int cnt;
  } wr_t;

  int  ref_tbl [N];
  wr_t pend[$];
  wr_t exp_wr[$];
  int  exp_lk[$];
  bit  ref_run;
  int  sweep;
  int  n_checks = 0;
  int  n_errors = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  // One clock: drive inputs, check handshake outputs, advance the model
  task automatic cycle(input bit rst_n, input bit lv, input int lidx,
                       input bit uv, input int uidx, input int ucnt, input bit ut);
    bit  full;
    int  nc;
    wr_t w;
    @(negedge clk);
    reset_i            = rst_n;
    fe_if.lookup_v_i   = lv;
    fe_if.lookup_idx_i = IW'(lidx);
    fe_if.upd_v_i      = uv;
    fe_if.upd_idx_i    = IW'(uidx);
    fe_if.upd_cnt_i    = CW'(ucnt);
    fe_if.upd_taken_i  = ut;
    #1;
    if (!rst_n) begin
      chk("rst_init_done", 32'(init_done_o), 0);
      chk("rst_lookup_ready", 32'(fe_if.lookup_ready_o), 0);
      chk("rst_upd_ready", 32'(fe_if.upd_ready_o), 0);
      chk("rst_lookup_v", 32'(fe_if.lookup_v_o), 0);
      chk("rst_bht_v", 32'(bht_v_o), 0);
      chk("rst_bht_w", 32'(bht_w_o), 0);
      chk("rst_bht_idx", 32'(bht_idx_o), 0);
      chk("rst_bht_data", 32'(bht_data_o), 0);
      pend.delete();
      exp_lk.delete();
      ref_run = 1'b0;
      sweep   = 0;
    end else if (!ref_run) begin
      chk("init_done_low", 32'(init_done_o), 0);
      chk("init_lookup_ready", 32'(fe_if.lookup_ready_o), 0);
      chk("init_upd_ready", 32'(fe_if.upd_ready_o), 0);
      exp_wr.push_back('{sweep, WNT});
      ref_tbl[sweep] = WNT;
      sweep++;
      if (sweep == N) ref_run = 1'b1;
    end else begin
      full = (pend.size() == FE);
      chk("init_done_high", 32'(init_done_o), 1);
      chk("lookup_ready", 32'(fe_if.lookup_ready_o), 32'(!full));
      chk("upd_ready", 32'(fe_if.upd_ready_o), 32'(!full));
      if (full || (!lv && pend.size() > 0)) begin
        w = pend.pop_front();
        ref_tbl[w.idx] = w.cnt;
        exp_wr.push_back(w);
      end else if (lv) begin
        exp_lk.push_back(ref_tbl[lidx]);
      end
      if (uv && !full) begin
        nc = ucnt;
        if (ut && ucnt < MAX) nc = ucnt + 1;
        else if (!ut && ucnt > 0) nc = ucnt - 1;
        if (nc != ucnt) pend.push_back('{uidx, nc});
      end
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cycle(1, 0, 0, 0, 0, 0, 0);
  endtask

  // Monitor: compares every table write and lookup response as the DUT presents it
  initial begin
    int  c;
    wr_t w;
    forever begin
      @(negedge clk);
      #2;
      if (fe_if.lookup_v_o === 1'b1) begin
        if (exp_lk.size() == 0) begin
          chk("unexpected_lookup_v", 1, 0);
        end else begin
          c = exp_lk.pop_front();
          chk("lookup_cnt", 32'(fe_if.lookup_cnt_o), 32'(c));
          chk("lookup_pred", 32'(fe_if.lookup_pred_o), 32'((c >> (CW - 1)) & 1));
        end
      end
      if (bht_v_o === 1'b1 && bht_w_o === 1'b1) begin
        if (exp_wr.size() == 0) begin
          chk("unexpected_write", 32'(bht_idx_o), 32'hFFFF_FFFF);
        end else begin
          w = exp_wr.pop_front();
          chk("write_idx", 32'(bht_idx_o), 32'(w.idx));
          chk("write_data", 32'(bht_data_o), 32'(w.cnt));
        end
      end
    end
  end

  initial begin
    reset_i            = 1'b0;
    fe_if.lookup_v_i   = 1'b0;
    fe_if.lookup_idx_i = '0;
    fe_if.upd_v_i      = 1'b0;
    fe_if.upd_idx_i    = '0;
    fe_if.upd_cnt_i    = '0;
    fe_if.upd_taken_i  = 1'b0;
    for (int i = 0; i < N; i++) mem[i] = CW'(MAX);
    ref_run = 1'b0;
    sweep   = 0;

    for (int i = 0; i < 3; i++) cycle(0, 0, 0, 0, 0, 0, 0);
    idle(N + 1);

    // Lookup after sweep returns weak-not-taken
    cycle(1, 1, 37, 0, 0, 0, 0);
    idle(2);

    // Single update then lookup of the same entry
    cycle(1, 0, 0, 1, 5, 1, 1);
    idle(2);
    cycle(1, 1, 5, 0, 0, 0, 0);
    idle(2);

    // Saturated updates: accepted, no write
    cycle(1, 0, 0, 1, 7, MAX, 1);
    cycle(1, 0, 0, 1, 8, 0, 0);
    idle(3);

    // Continuous lookups fill the FIFO, forcing a drain
    for (int i = 0; i < 12; i++)
      cycle(1, 1, 100 + i, (i < 7) ? 1'b1 : 1'b0, 40 + i, 1, 1);
    idle(8);

    // Same-index updates drain in order
    cycle(1, 0, 0, 1, 9, 1, 1);
    cycle(1, 0, 0, 1, 9, 2, 1);
    idle(3);
    cycle(1, 1, 9, 0, 0, 0, 0);
    idle(2);

    // Random traffic over a small index range to provoke collisions
    for (int i = 0; i < 3000; i++)
      cycle(1, 1'($urandom_range(0, 1)), int'($urandom_range(0, 15)),
            1'($urandom_range(0, 1)), int'($urandom_range(0, 15)),
            int'($urandom_range(0, MAX)), 1'($urandom_range(0, 1)));
    idle(8);

    // Mid-run reset with three pending updates and a lookup in flight
    for (int i = 0; i < 3; i++) cycle(1, 1, 60 + i, 1, 20 + i, 1, 1);
    cycle(0, 1, 61, 1, 23, 1, 1);
    idle(N + 4);

    for (int i = 0; i < 300; i++)
      cycle(1, 1'($urandom_range(0, 1)), int'($urandom_range(0, N - 1)),
            1'($urandom_range(0, 1)), int'($urandom_range(0, 31)),
            int'($urandom_range(0, MAX)), 1'($urandom_range(0, 1)));
    idle(10);

    chk("lookups_outstanding", 32'(exp_lk.size()), 0);
    chk("writes_outstanding", 32'(exp_wr.size()), 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
